// File: rtl/sr_latch_driver.sv
// -----------------------------------------------------------------------------
// sr_latch_driver
//
// Purpose:
//     Clocked front end for the asynchronous sr_latch. Turns a valid/ready
//     stream of requested latch levels into mutually exclusive, fixed-length
//     set/reset pulses followed by a quiet settle window. Once the latch has
//     settled, and on every cycle while idle, the latch outputs are compared
//     against the commanded level and any disagreement (or a forbidden
//     Q == Qn condition) raises a sticky error flag.
//
// Parameters:
//     PULSE_LEN   cycles o_s / o_r is held high per level change (1..255)
//     SETTLE_LEN  quiet cycles after a pulse before the latch is checked (1..255)
//
// Ports:
//     i_clk      rising-edge clock
//     i_rst_n    asynchronous active-low reset
//     i_valid    request valid
//     i_d        requested latch level (1 = set, 0 = reset)
//     o_ready    request accepted on an edge where i_valid && o_ready
//     o_s        drives latch i_s
//     o_r        drives latch i_r
//     i_q        latch o_q
//     i_qn       latch o_qn
//     o_state    level the latch is commanded to hold
//     o_err      sticky latch-mismatch flag
//     i_err_clr  synchronous clear of o_err (a new error on the same edge wins)
// -----------------------------------------------------------------------------
module sr_latch_driver #(
    parameter int PULSE_LEN  = 2,
    parameter int SETTLE_LEN = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_valid,
    input  logic i_d,
    output logic o_ready,
    output logic o_s,
    output logic o_r,
    input  logic i_q,
    input  logic i_qn,
    output logic o_state,
    output logic o_err,
    input  logic i_err_clr
);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_PULSE,
        ST_SETTLE
    } state_t;

    // Terminal counts for each timed phase; the counter runs 0..LEN-1.
    localparam logic [7:0] PULSE_LAST  = 8'(PULSE_LEN - 1);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_LEN - 1);

    state_t     r_fsm;
    logic [7:0] r_cnt;
    logic       r_ready;
    logic       r_s;
    logic       r_r;
    logic       r_state;
    logic       r_err;

    logic w_accept;
    logic w_change;
    logic w_checkNow;
    logic w_latchBad;
    logic w_pulseDone;
    logic w_settleDone;

    assign o_ready = r_ready;
    assign o_s     = r_s;
    assign o_r     = r_r;
    assign o_state = r_state;
    assign o_err   = r_err;

    assign w_accept     = i_valid && r_ready;
    assign w_change     = w_accept && (i_d != r_state);
    assign w_pulseDone  = (r_cnt == PULSE_LAST);
    assign w_settleDone = (r_cnt == SETTLE_LAST);

    // The latch is only trusted once the settle window has fully elapsed, so
    // the check is live on the edge closing the last settle cycle and on every
    // idle edge. During a pulse the outputs are legitimately in transition.
    assign w_checkNow = (r_fsm == ST_IDLE) ||
                        ((r_fsm == ST_SETTLE) && w_settleDone);
    assign w_latchBad = (i_q != r_state) || (i_q == i_qn);

    // Single state machine; every output is a register. o_s and o_r are only
    // ever loaded as a complementary pair from one bit (or both cleared), so
    // the forbidden S=R=1 combination cannot be produced by construction.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fsm   <= ST_INIT;
            r_cnt   <= 8'd0;
            r_ready <= 1'b0;
            r_s     <= 1'b0;
            r_r     <= 1'b0;
            r_state <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            // Detection takes priority over clear so a fault present on the
            // clearing edge is never lost.
            if (w_checkNow && w_latchBad) begin
                r_err <= 1'b1;
            end else if (i_err_clr) begin
                r_err <= 1'b0;
            end

            case (r_fsm)
                // Power-up state of the latch is unknown, so force a reset
                // pulse before accepting any request. r_state is already 0.
                ST_INIT: begin
                    r_s     <= 1'b0;
                    r_r     <= 1'b1;
                    r_ready <= 1'b0;
                    r_cnt   <= 8'd0;
                    r_fsm   <= ST_PULSE;
                end

                // Redundant requests are absorbed here without a pulse so
                // they can be accepted back to back.
                ST_IDLE: begin
                    r_cnt <= 8'd0;
                    if (w_change) begin
                        r_state <= i_d;
                        r_ready <= 1'b0;
                        r_s     <= i_d;
                        r_r     <= ~i_d;
                        r_fsm   <= ST_PULSE;
                    end else begin
                        r_s     <= 1'b0;
                        r_r     <= 1'b0;
                        r_ready <= 1'b1;
                    end
                end

                ST_PULSE: begin
                    if (w_pulseDone) begin
                        r_s   <= 1'b0;
                        r_r   <= 1'b0;
                        r_cnt <= 8'd0;
                        r_fsm <= ST_SETTLE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end

                ST_SETTLE: begin
                    if (w_settleDone) begin
                        r_cnt   <= 8'd0;
                        r_ready <= 1'b1;
                        r_fsm   <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end

                // Unreachable encoding: drop both drives and re-initialise.
                default: begin
                    r_s     <= 1'b0;
                    r_r     <= 1'b0;
                    r_ready <= 1'b0;
                    r_cnt   <= 8'd0;
                    r_fsm   <= ST_INIT;
                end
            endcase
        end
    end

endmodule
